// File: rtl/force_release_reg.sv
// Storage register whose output normally follows d one cycle late, but can be
// overridden by a timed or indefinite force, with ack/done pulses and a masked-activity count.
module force_release_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             frc_req,
  input  logic [WIDTH-1:0] frc_val,
  input  logic [LEN_W-1:0] frc_len,
  input  logic             rel_req,
  output logic [WIDTH-1:0] q,
  output logic             forced,
  output logic             frc_ack,
  output logic             done,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FORCED = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_prev_q, d_prev_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             forced_q, forced_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] miss_q, miss_d;

  // Handshake: frc_req/rel_req are level-sampled at every rising edge (no ready);
  // frc_ack and done are single-cycle registered pulses answering those samples.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    forced_d = forced_q;
    ack_d    = 1'b0;
    done_d   = 1'b0;
    d_prev_d = d;
    miss_d   = miss_q;

    if (state_q == ST_FORCED && d != d_prev_q && miss_q != {CNT_W{1'b1}}) begin
      miss_d = miss_q + 1'b1;
    end

    // A new request always wins, whether idle, re-forcing, releasing or expiring.
    if (frc_req) begin
      state_d  = ST_FORCED;
      q_d      = frc_val;
      cnt_d    = frc_len;
      forced_d = 1'b1;
      ack_d    = 1'b1;
    end else if (state_q == ST_IDLE) begin
      q_d = d;
    end else if (rel_req || cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) begin
      state_d  = ST_IDLE;
      q_d      = d;
      cnt_d    = '0;
      forced_d = 1'b0;
      done_d   = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      q_q      <= '0;
      d_prev_q <= '0;
      cnt_q    <= '0;
      forced_q <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      d_prev_q <= d_prev_d;
      cnt_q    <= cnt_d;
      forced_q <= forced_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      miss_q   <= miss_d;
    end
  end

  assign q        = q_q;
  assign forced   = forced_q;
  assign frc_ack  = ack_q;
  assign done     = done_q;
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_force_release_reg.sv
// Bench for force_release_reg: directed scenarios then random traffic, both checked
// against an edge-numbered reference model; a CNT_W=2 copy shares stimulus for saturation.
module tb_force_release_reg;

  logic       clk;
  logic       rst;
  logic [7:0] d;
  logic       frc_req;
  logic [7:0] frc_val;
  logic [3:0] frc_len;
  logic       rel_req;

  logic [7:0] q, q2;
  logic       forced, forced2, frc_ack, frc_ack2, done, done2;
  logic [7:0] miss_cnt;
  logic [1:0] miss_cnt2;

  int tests_run = 0;
  int tests_failed = 0;
  int edge_num = 0;

  // reference model state
  logic [7:0] m_q;
  logic       m_forced, m_ack, m_done;
  logic [7:0] m_dprev;
  int         m_expire;
  int         m_miss8, m_miss2;

  force_release_reg #(.WIDTH(8), .LEN_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .d(d), .frc_req(frc_req), .frc_val(frc_val),
    .frc_len(frc_len), .rel_req(rel_req), .q(q), .forced(forced),
    .frc_ack(frc_ack), .done(done), .miss_cnt(miss_cnt)
  );

  force_release_reg #(.WIDTH(8), .LEN_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .d(d), .frc_req(frc_req), .frc_val(frc_val),
    .frc_len(frc_len), .rel_req(rel_req), .q(q2), .forced(forced2),
    .frc_ack(frc_ack2), .done(done2), .miss_cnt(miss_cnt2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rst = 1'b1; d = '0; frc_req = 1'b0; frc_val = '0; frc_len = '0; rel_req = 1'b0;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, edge_num);
    end
  endtask

  // Model: a timed force accepted at edge e with length N ends at edge e+N.
  task automatic model_edge();
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      m_q = '0; m_forced = 1'b0; m_dprev = '0; m_expire = -1;
      m_miss8 = 0; m_miss2 = 0;
    end else begin
      if (m_forced && d != m_dprev) begin
        if (m_miss8 < 255) m_miss8++;
        if (m_miss2 < 3) m_miss2++;
      end
      if (frc_req) begin
        m_q = frc_val; m_forced = 1'b1; m_ack = 1'b1;
        m_expire = (frc_len == 0) ? -1 : edge_num + int'(frc_len);
      end else if (m_forced && (rel_req || edge_num == m_expire)) begin
        m_q = d; m_forced = 1'b0; m_done = 1'b1;
      end else if (!m_forced) begin
        m_q = d;
      end
      m_dprev = d;
    end
  endtask

  task automatic compare_all();
    check_val("q", q, m_q);
    check_val("forced", forced, m_forced);
    check_val("frc_ack", frc_ack, m_ack);
    check_val("done", done, m_done);
    check_val("miss_cnt", miss_cnt, m_miss8);
    check_val("q_sat", q2, m_q);
    check_val("done_sat", done2, m_done);
    check_val("miss_cnt_sat", miss_cnt2, m_miss2);
  endtask

  // driver: apply inputs away from the edge, advance model, sample after the edge
  task automatic cyc(input logic r, input logic [7:0] dv, input logic fr,
                     input logic [7:0] fv, input logic [3:0] fl, input logic rr);
    @(negedge clk);
    rst = r; d = dv; frc_req = fr; frc_val = fv; frc_len = fl; rel_req = rr;
    edge_num++;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] tog;
    logic       r, fr, rr;
    int         p;

    // 1: reset then pass-through
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
    check_val("rst_q", q, 8'h00);
    check_val("rst_miss", miss_cnt, 8'h00);
    cyc(0, 8'h5A, 0, 8'h00, 0, 0);
    check_val("pass_q", q, 8'h5A);

    // 2: timed force of 3 cycles
    cyc(0, 8'h00, 1, 8'hFF, 4'd3, 0);
    check_val("t2_ack", frc_ack, 1);
    check_val("t2_q0", q, 8'hFF);
    cyc(0, 8'h00, 0, 8'h77, 0, 0);
    check_val("t2_ack_pulse", frc_ack, 0);
    cyc(0, 8'h00, 0, 8'h77, 0, 0);
    check_val("t2_q2", q, 8'hFF);
    cyc(0, 8'h00, 0, 8'h77, 0, 0);
    check_val("t2_q_rel", q, 8'h00);
    check_val("t2_done", done, 1);
    cyc(0, 8'h00, 0, 8'h00, 0, 0);
    check_val("t2_done_pulse", done, 0);

    // 3: indefinite hold, explicit release
    cyc(0, 8'h00, 1, 8'hA5, 4'd0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 8'($urandom_range(0, 255)), 0, 8'h00, 4'd1, 0);
    check_val("t3_hold", q, 8'hA5);
    cyc(0, 8'h3C, 0, 8'h00, 0, 1);
    check_val("t3_rel_q", q, 8'h3C);
    check_val("t3_rel_forced", forced, 0);
    check_val("t3_rel_done", done, 1);

    // 4: re-force mid-hold, force+release together, release while idle
    cyc(0, 8'h20, 1, 8'h55, 4'd5, 0);
    cyc(0, 8'h21, 0, 8'h00, 0, 0);
    cyc(0, 8'h22, 1, 8'h11, 4'd2, 0);
    check_val("t4_ack2", frc_ack, 1);
    cyc(0, 8'h23, 0, 8'h00, 0, 0);
    check_val("t4_q11", q, 8'h11);
    check_val("t4_no_done", done, 0);
    cyc(0, 8'h24, 0, 8'h00, 0, 0);
    check_val("t4_done", done, 1);
    cyc(0, 8'h25, 1, 8'h66, 4'd0, 0);
    cyc(0, 8'h26, 1, 8'h67, 4'd0, 1);
    check_val("t4_both_done", done, 0);
    check_val("t4_both_q", q, 8'h67);
    cyc(0, 8'h27, 0, 8'h00, 0, 1);
    cyc(0, 8'h28, 0, 8'h00, 0, 1);
    check_val("t4_idle_rel", done, 0);

    // 5: masked toggles counted; narrow counter saturates
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 8'h99, 4'd5, 0);
    tog = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      cyc(0, tog, 0, 8'h00, 0, 0);
      tog = ~tog;
    end
    check_val("t5_miss5", miss_cnt, 8'd5);
    check_val("t5_end_done", done, 1);
    cyc(0, tog, 1, 8'h42, 4'd0, 0);
    for (int i = 0; i < 10; i++) begin
      tog = ~tog;
      cyc(0, tog, 0, 8'h00, 0, 0);
    end
    check_val("t5_sat", miss_cnt2, 2'd3);
    cyc(0, tog, 0, 8'h00, 0, 1);

    // 6: reset in the middle of a long force
    cyc(0, 8'h10, 1, 8'hC3, 4'd10, 0);
    cyc(0, 8'h11, 0, 8'h00, 0, 0);
    cyc(1, 8'h12, 0, 8'h00, 0, 0);
    check_val("t6_q", q, 8'h00);
    check_val("t6_forced", forced, 0);
    check_val("t6_miss", miss_cnt, 8'h00);
    check_val("t6_done", done, 0);
    cyc(0, 8'h13, 1, 8'hE1, 4'd2, 0);
    cyc(0, 8'h14, 0, 8'h00, 0, 0);
    cyc(0, 8'h15, 0, 8'h00, 0, 0);
    check_val("t6_after", done, 1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      p  = int'($urandom_range(0, 99));
      r  = (p < 2);
      fr = ($urandom_range(0, 99) < 12);
      rr = ($urandom_range(0, 99) < 8);
      cyc(r, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : d, fr,
          8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), rr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
